uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter for the SOC, succeeding the fixed 8N1 TXD path. Words written on a valid/ready port are buffered in an internal FIFO and serialised onto TXD. Data width, parity mode, stop-bit count and FIFO depth are parametrised, and the baud divisor is a runtime input. It sits between the CPU's memory-mapped IO decode and the SOC's TXD pin.

## Interface
- DATA_BITS, 8, payload bits per frame (5..9)
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, stop bits per frame (1 or 2)
- FIFO_DEPTH, 4, FIFO entries (power of two, >= 2)
- DIV_WIDTH, 16, width of the divisor input
- CLK  in  1  single system clock, rising edge
- RESETN  in  1  asynchronous, active-low reset
- DIVISOR  in  DIV_WIDTH  clock cycles per bit; a value of 0 is treated as 1
- WR_DATA  in  DATA_BITS  word to transmit
- WR_VALID  in  1  write request
- WR_READY  out  1  FIFO not full; registered
- TXD  out  1  serial output; idle high; registered
- BUSY  out  1  frame in progress or FIFO non-empty
- FIFO_COUNT  out  $clog2(FIFO_DEPTH+1)  occupied entries

## Operation
- Reset (async on RESETN low):
  - TXD=1, WR_READY=1, BUSY=0, FIFO_COUNT=0.
  - FIFO pointers are cleared and the FSM goes to IDLE.
  - A frame in flight is abandoned and TXD rises immediately.
- Push: occurs when WR_VALID && WR_READY at a rising edge. WR_VALID while WR_READY=0 is ignored; the word is dropped and nothing changes.
- Pop: the FSM takes the head entry when it leaves IDLE, or when the last stop-bit cycle ends and the FIFO is non-empty.
- Push and pop on the same edge: FIFO_COUNT is unchanged and both operations take effect.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START when the FIFO is non-empty. Pop the word, latch DIVISOR (a value of 0 latches as 1), and drive TXD=0.
  - START -> DATA after one bit time. DATA sends DATA_BITS bits LSB-first, one bit time each.
  - DATA -> PAR when PARITY != 0; otherwise DATA -> STOP.
  - PAR drives the XOR of the data bits for even parity and its inverse for odd parity.
  - STOP drives TXD=1 for STOP_BITS bit times.
  - At the end of STOP: go directly to START if the FIFO is non-empty, with no idle gap. Otherwise go to IDLE.
- Bit timing: a down-counter loaded with the latched divisor minus 1; the bit ends when it reaches 0. Changing DIVISOR mid-frame has no effect until the next frame.
- Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. Full/empty status comes from FIFO_COUNT.
- WR_READY = (FIFO_COUNT != FIFO_DEPTH), registered. It is never combinational on WR_VALID.
- BUSY = (state != IDLE) || (FIFO_COUNT != 0).

## Timing
- Push at edge N into an empty FIFO with the FSM in IDLE:
  - FIFO_COUNT=1 after edge N.
  - At edge N+1 the FSM pops the word. TXD=0 and FIFO_COUNT=0 after N+1.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × D cycles, where D is the latched divisor.
- Each TXD level is held exactly D cycles. There are no glitches between bits of the same value.
- Back-to-back frames: the next start bit begins on the cycle immediately after the final stop-bit cycle.
- WR_READY falls on the edge whose push fills the FIFO. It rises on the edge of the next pop.
- RESETN deassertion is synchronous to CLK. The first push is accepted on the first rising edge with RESETN=1.

## Test plan
- 8N1, DIVISOR=4, push 0x55 -> TXD sequence 0,1,0,1,0,1,0,1,0,1, each level for 4 cycles. TXD falls 1 cycle after the push. BUSY=0 at cycle 41 after the push.
- PARITY=1, DIVISOR=2, push 0x07 -> parity bit 1. PARITY=2 with the same word -> parity bit 0. Frame length 22 cycles.
- DIVISOR=100, push on consecutive cycles -> first word popped, next 4 words fill the FIFO (5 accepted). WR_READY=0 and FIFO_COUNT=4. The 6th word is dropped. Frames emitted back-to-back with no high gap between stop and start.
- DIVISOR=0 with 8N1 -> behaves as DIVISOR=1. Frame of 10 cycles, TXD toggles each cycle for 0x55.
- Assert RESETN low at the middle of a data bit with 3 words queued -> TXD=1 and FIFO_COUNT=0 immediately. After release, TXD stays idle-high and the next push starts a clean frame.
- DIVISOR changed from 4 to 8 mid-frame -> the current frame keeps 4-cycle bits. The next frame uses 8-cycle bits.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter: valid/ready words are queued in a FIFO and sent as frames on TXD.
// Pops one cycle after a push into an idle, empty block; WR_READY drops while the FIFO is full, and writes made then are dropped.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                               CLK,
  input  logic                               RESETN,
  input  logic [DIV_WIDTH-1:0]               DIVISOR,
  input  logic [DATA_BITS-1:0]               WR_DATA,
  input  logic                               WR_VALID,
  output logic                               WR_READY,
  output logic                               TXD,
  output logic                               BUSY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    FIFO_COUNT
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state, state_n;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count, count_n;
  logic                   push, pop, load;
  logic [DIV_WIDTH-1:0]   div_q, div_n, cnt_q, cnt_n, div_eff;
  logic [DATA_BITS-1:0]   sh_q, sh_n, head;
  logic [IW-1:0]          idx_q, idx_n;
  logic                   par_q, par_n, stop_q, stop_n, txd_n;

  assign push       = WR_VALID && WR_READY;
  assign head       = mem[rd_ptr];
  assign div_eff    = (DIVISOR == '0) ? DIV_WIDTH'(1) : DIVISOR;
  assign FIFO_COUNT = count;
  assign BUSY       = (state != IDLE) || (count != '0);

  always_comb begin
    count_n = count;
    if (push && !pop)
      count_n = count + CW'(1);
    else if (!push && pop)
      count_n = count - CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wr_ptr] <= WR_DATA;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      WR_READY <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count    <= count_n;
      WR_READY <= (count_n != CW'(FIFO_DEPTH));
    end
  end

  // Every bit ends when the down-counter hits zero; the next level is registered on that edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt_q;
    div_n   = div_q;
    sh_n    = sh_q;
    idx_n   = idx_q;
    par_n   = par_q;
    stop_n  = stop_q;
    txd_n   = TXD;
    load    = 1'b0;
    pop     = 1'b0;

    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (count != '0)
          load = 1'b1;
      end
      START: begin
        if (cnt_q == '0) begin
          state_n = DATA;
          txd_n   = sh_q[0];
          sh_n    = sh_q >> 1;
          idx_n   = IW'(DATA_BITS - 1);
          cnt_n   = div_q - DIV_WIDTH'(1);
        end else begin
          cnt_n = cnt_q - DIV_WIDTH'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_n = div_q - DIV_WIDTH'(1);
          if (idx_q != '0) begin
            txd_n = sh_q[0];
            sh_n  = sh_q >> 1;
            idx_n = idx_q - IW'(1);
          end else if (PARITY != 0) begin
            state_n = PAR;
            txd_n   = par_q;
          end else begin
            state_n = STOP;
            txd_n   = 1'b1;
            stop_n  = (STOP_BITS == 2);
          end
        end else begin
          cnt_n = cnt_q - DIV_WIDTH'(1);
        end
      end
      PAR: begin
        if (cnt_q == '0) begin
          state_n = STOP;
          txd_n   = 1'b1;
          stop_n  = (STOP_BITS == 2);
          cnt_n   = div_q - DIV_WIDTH'(1);
        end else begin
          cnt_n = cnt_q - DIV_WIDTH'(1);
        end
      end
      STOP: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - DIV_WIDTH'(1);
        end else if (stop_q) begin
          stop_n = 1'b0;
          cnt_n  = div_q - DIV_WIDTH'(1);
        end else if (count != '0) begin
          load = 1'b1;
        end else begin
          state_n = IDLE;
          txd_n   = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase

    // Start a new frame: divisor is sampled only here, so mid-frame changes wait for the next word.
    if (load) begin
      pop     = 1'b1;
      state_n = START;
      txd_n   = 1'b0;
      div_n   = div_eff;
      cnt_n   = div_eff - DIV_WIDTH'(1);
      sh_n    = head;
      par_n   = (^head) ^ (PARITY == 2);
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state  <= IDLE;
      TXD    <= 1'b1;
      cnt_q  <= '0;
      div_q  <= '0;
      sh_q   <= '0;
      idx_q  <= '0;
      par_q  <= 1'b0;
      stop_q <= 1'b0;
    end else begin
      state  <= state_n;
      TXD    <= txd_n;
      cnt_q  <= cnt_n;
      div_q  <= div_n;
      sh_q   <= sh_n;
      idx_q  <= idx_n;
      par_q  <= par_n;
      stop_q <= stop_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8N1 instance plus even- and odd-parity instances.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] div, div_p;
  logic [7:0]  wr_data, wr_data_p;
  logic        wr_valid, wr_valid_p;
  logic        wr_ready, txd, busy;
  logic [2:0]  fifo_count;
  logic        rdy_e, txd_e, busy_e, rdy_o, txd_o, busy_o;
  logic [2:0]  cnt_e, cnt_o;
  int          checks = 0;
  int          errors = 0;

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .CLK(clk), .RESETN(resetn), .DIVISOR(div), .WR_DATA(wr_data), .WR_VALID(wr_valid),
    .WR_READY(wr_ready), .TXD(txd), .BUSY(busy), .FIFO_COUNT(fifo_count));

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut_even (
    .CLK(clk), .RESETN(resetn), .DIVISOR(div_p), .WR_DATA(wr_data_p), .WR_VALID(wr_valid_p),
    .WR_READY(rdy_e), .TXD(txd_e), .BUSY(busy_e), .FIFO_COUNT(cnt_e));

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut_odd (
    .CLK(clk), .RESETN(resetn), .DIVISOR(div_p), .WR_DATA(wr_data_p), .WR_VALID(wr_valid_p),
    .WR_READY(rdy_o), .TXD(txd_o), .BUSY(busy_o), .FIFO_COUNT(cnt_o));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Time-ordered TXD levels of an 8N1 frame: bit 0 is the start bit.
  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  task automatic check_frame(input string tag, input logic [15:0] bits, input int nlev,
                             input int d, input int start);
    for (int k = start; k < nlev * d; k++) begin
      chk({tag, "_txd"}, {31'b0, txd}, {31'b0, bits[k / d]});
      chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
      tick();
    end
  endtask

  initial begin
    logic [15:0] fe, fo;
    resetn = 1'b1; div = 16'd4; div_p = 16'd2;
    wr_data = 8'h00; wr_valid = 1'b0; wr_data_p = 8'h00; wr_valid_p = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_txd", {31'b0, txd}, 32'd1);
    chk("rst_ready", {31'b0, wr_ready}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_count", {29'b0, fifo_count}, 32'd0);
    tick();
    tick();

    // 8N1, divisor 4, word pushed on the first edge after reset release
    resetn = 1'b1; wr_data = 8'h55; wr_valid = 1'b1; div = 16'd4;
    tick();
    wr_valid = 1'b0;
    chk("t1_count_push", {29'b0, fifo_count}, 32'd1);
    chk("t1_txd_idle", {31'b0, txd}, 32'd1);
    chk("t1_busy_push", {31'b0, busy}, 32'd1);
    tick();
    chk("t1_count_pop", {29'b0, fifo_count}, 32'd0);
    check_frame("t1", f8n1(8'h55), 10, 4, 0);
    chk("t1_busy_end", {31'b0, busy}, 32'd0);
    chk("t1_txd_end", {31'b0, txd}, 32'd1);

    // Even and odd parity, divisor 2, word 0x07 -> parity bits 1 and 0, 22-cycle frame
    fe = {5'b0, 1'b1, 1'b1, 8'h07, 1'b0};
    fo = {5'b0, 1'b1, 1'b0, 8'h07, 1'b0};
    wr_data_p = 8'h07; wr_valid_p = 1'b1; div_p = 16'd2;
    tick();
    wr_valid_p = 1'b0;
    chk("par_cnt_e", {29'b0, cnt_e}, 32'd1);
    chk("par_cnt_o", {29'b0, cnt_o}, 32'd1);
    tick();
    for (int k = 0; k < 22; k++) begin
      chk("par_txd_e", {31'b0, txd_e}, {31'b0, fe[k / 2]});
      chk("par_txd_o", {31'b0, txd_o}, {31'b0, fo[k / 2]});
      if (k == 21) chk("par_busy_last", {31'b0, busy_e}, 32'd1);
      tick();
    end
    chk("par_busy_e_end", {31'b0, busy_e}, 32'd0);
    chk("par_busy_o_end", {31'b0, busy_o}, 32'd0);
    chk("par_rdy_e", {31'b0, rdy_e}, 32'd1);
    chk("par_rdy_o", {31'b0, rdy_o}, 32'd1);

    // Divisor 0 acts as 1: 10-cycle frame toggling each cycle
    wr_data = 8'h55; wr_valid = 1'b1; div = 16'd0;
    tick();
    wr_valid = 1'b0;
    tick();
    check_frame("div0", f8n1(8'h55), 10, 1, 0);
    chk("div0_busy_end", {31'b0, busy}, 32'd0);

    // Divisor changes 4 -> 8 mid-frame; push and pop share an edge
    wr_data = 8'h55; wr_valid = 1'b1; div = 16'd4;
    tick();
    wr_data = 8'h0F;
    tick();
    wr_valid = 1'b0; div = 16'd8;
    chk("dchg_count_pushpop", {29'b0, fifo_count}, 32'd1);
    check_frame("dchg_a", f8n1(8'h55), 10, 4, 0);
    check_frame("dchg_b", f8n1(8'h0F), 10, 8, 0);
    chk("dchg_busy_end", {31'b0, busy}, 32'd0);

    // Divisor 100, six consecutive pushes: five accepted, sixth dropped, frames back-to-back
    div = 16'd100; wr_valid = 1'b1; wr_data = 8'hA5;
    tick();
    wr_data = 8'h3C;
    chk("fill_c1", {29'b0, fifo_count}, 32'd1);
    tick();
    wr_data = 8'hF0;
    chk("fill_c2", {29'b0, fifo_count}, 32'd1);
    tick();
    wr_data = 8'h0F;
    chk("fill_c3", {29'b0, fifo_count}, 32'd2);
    tick();
    wr_data = 8'h81;
    chk("fill_c4", {29'b0, fifo_count}, 32'd3);
    chk("fill_rdy4", {31'b0, wr_ready}, 32'd1);
    tick();
    wr_data = 8'hFF;
    chk("fill_c5", {29'b0, fifo_count}, 32'd4);
    chk("fill_rdy5", {31'b0, wr_ready}, 32'd0);
    tick();
    wr_valid = 1'b0;
    chk("fill_c6", {29'b0, fifo_count}, 32'd4);
    chk("fill_rdy6", {31'b0, wr_ready}, 32'd0);
    check_frame("fill_w0", f8n1(8'hA5), 10, 100, 4);
    chk("fill_rdy_pop", {31'b0, wr_ready}, 32'd1);
    chk("fill_c_pop", {29'b0, fifo_count}, 32'd3);
    check_frame("fill_w1", f8n1(8'h3C), 10, 100, 0);
    check_frame("fill_w2", f8n1(8'hF0), 10, 100, 0);
    check_frame("fill_w3", f8n1(8'h0F), 10, 100, 0);
    check_frame("fill_w4", f8n1(8'h81), 10, 100, 0);
    chk("fill_busy_end", {31'b0, busy}, 32'd0);
    chk("fill_count_end", {29'b0, fifo_count}, 32'd0);

    // Reset in the middle of data bit 0 with three words queued
    div = 16'd4; wr_valid = 1'b1; wr_data = 8'h54;
    tick();
    wr_data = 8'h11;
    tick();
    wr_data = 8'h22;
    tick();
    wr_data = 8'h33;
    tick();
    wr_valid = 1'b0;
    chk("rmid_count", {29'b0, fifo_count}, 32'd3);
    tick();
    tick();
    tick();
    chk("rmid_txd_low", {31'b0, txd}, 32'd0);
    resetn = 1'b0;
    #1;
    chk("rmid_txd", {31'b0, txd}, 32'd1);
    chk("rmid_count0", {29'b0, fifo_count}, 32'd0);
    chk("rmid_busy", {31'b0, busy}, 32'd0);
    chk("rmid_ready", {31'b0, wr_ready}, 32'd1);
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rmid_idle_txd", {31'b0, txd}, 32'd1);
      chk("rmid_idle_busy", {31'b0, busy}, 32'd0);
    end
    wr_data = 8'h55; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    tick();
    check_frame("rmid_clean", f8n1(8'h55), 10, 4, 0);
    chk("rmid_busy_end", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
